// File: rtl/shifter_pkg.sv
// Mode encoding and mode classification helpers shared by the pipelined
// barrel shifter and its stages.
package shifter_pkg;

  localparam logic [2:0] MODE_SLL = 3'b000;
  localparam logic [2:0] MODE_SRL = 3'b001;
  localparam logic [2:0] MODE_SRA = 3'b010;
  localparam logic [2:0] MODE_ROL = 3'b011;
  localparam logic [2:0] MODE_ROR = 3'b100;

  function automatic logic mode_legal(input logic [2:0] mode);
    return mode <= MODE_ROR;
  endfunction

  // Left operations run through the right-shift core on bit-reversed data.
  function automatic logic mode_left(input logic [2:0] mode);
    return (mode == MODE_SLL) || (mode == MODE_ROL);
  endfunction

  function automatic logic mode_rot(input logic [2:0] mode);
    return (mode == MODE_ROL) || (mode == MODE_ROR);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One register stage of the right-shift core: shifts by STEP when its amount
// bit is set, with a collapsing valid/ready handshake.
module shift_stage
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int TAG_W = 4,
  parameter  int STEP  = 1,
  localparam int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_amt,
  input  logic [2:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW-1:0]    out_amt,
  output logic [2:0]       out_mode,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam int K = $clog2(STEP);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [AW-1:0]    amt;
    logic [2:0]       mode;
    logic [TAG_W-1:0] tag;
    logic             err;
  } payload_t;

  payload_t         pl_d, pl_q;
  logic             vld_d, vld_q;
  logic [WIDTH-1:0] shifted;

  assign in_ready = !vld_q || out_ready;

  // SRA keeps the sign in the MSB at every stage, so each stage can use its own MSB as fill.
  always_comb begin
    shifted = in_data;
    if (in_amt[K]) begin
      if (mode_rot(in_mode)) begin
        shifted = (in_data >> STEP) | (in_data << (WIDTH - STEP));
      end else if (in_mode == MODE_SRA) begin
        shifted = $signed(in_data) >>> STEP;
      end else begin
        shifted = in_data >> STEP;
      end
    end
  end

  always_comb begin
    vld_d = vld_q;
    pl_d  = pl_q;
    if (in_ready) begin
      vld_d = in_valid;
      if (in_valid) begin
        pl_d.data = shifted;
        pl_d.amt  = in_amt;
        pl_d.mode = in_mode;
        pl_d.tag  = in_tag;
        pl_d.err  = in_err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      pl_q  <= '0;
    end else begin
      vld_q <= vld_d;
      pl_q  <= pl_d;
    end
  end

  assign out_valid = vld_q;
  assign out_data  = pl_q.data;
  assign out_amt   = pl_q.amt;
  assign out_mode  = pl_q.mode;
  assign out_tag   = pl_q.tag;
  assign out_err   = pl_q.err;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: SLL/SRL/SRA/ROL/ROR over WIDTH bits, one stage per
// shift-amount bit, valid/ready on both sides, tag and error carried along.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int TAG_W = 4,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [2:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  logic             vld_c  [0:SHW];
  logic             rdy_c  [0:SHW];
  logic [WIDTH-1:0] dat_c  [0:SHW];
  logic [SHW-1:0]   amt_c  [0:SHW];
  logic [2:0]       mode_c [0:SHW];
  logic [TAG_W-1:0] tag_c  [0:SHW];
  logic             err_c  [0:SHW];
  logic [SHW-1:0]   amt_unused;

  logic             s0_legal;
  logic [WIDTH-1:0] s0_data;

  // Illegal modes enter with a zero amount so the data passes through untouched.
  always_comb begin
    s0_legal = mode_legal(in_mode);
    s0_data  = in_data;
    if (s0_legal && mode_left(in_mode)) begin
      for (int i = 0; i < WIDTH; i++) s0_data[i] = in_data[WIDTH-1-i];
    end
  end

  assign vld_c[0]    = in_valid;
  assign in_ready    = rdy_c[0];
  assign dat_c[0]    = s0_data;
  assign amt_c[0]    = s0_legal ? in_amt : '0;
  assign mode_c[0]   = in_mode;
  assign tag_c[0]    = in_tag;
  assign err_c[0]    = !s0_legal;
  assign rdy_c[SHW]  = out_ready;
  assign amt_unused  = amt_c[SHW];

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .TAG_W (TAG_W),
      .STEP  (1 << k)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (vld_c[k]),
      .in_ready  (rdy_c[k]),
      .in_data   (dat_c[k]),
      .in_amt    (amt_c[k]),
      .in_mode   (mode_c[k]),
      .in_tag    (tag_c[k]),
      .in_err    (err_c[k]),
      .out_valid (vld_c[k+1]),
      .out_ready (rdy_c[k+1]),
      .out_data  (dat_c[k+1]),
      .out_amt   (amt_c[k+1]),
      .out_mode  (mode_c[k+1]),
      .out_tag   (tag_c[k+1]),
      .out_err   (err_c[k+1])
    );
  end

  always_comb begin
    out_data = dat_c[SHW];
    if (mode_left(mode_c[SHW])) begin
      for (int i = 0; i < WIDTH; i++) out_data[i] = dat_c[SHW][WIDTH-1-i];
    end
  end

  assign out_valid = vld_c[SHW];
  assign out_tag   = tag_c[SHW];
  assign out_err   = err_c[SHW];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter: 8-bit directed table plus a 32-bit
// instance driven with random ops and checked by a scoreboard model.
module tb_pipelined_barrel_shifter;

  localparam int SHW8  = 3;
  localparam int SHW32 = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       v8, ir8, ov8, or8, oe8;
  logic [7:0] d8, od8;
  logic [2:0] a8, m8;
  logic [3:0] t8, ot8;

  logic        v32, ir32, ov32, or32, oe32;
  logic [31:0] d32, od32;
  logic [4:0]  a32;
  logic [2:0]  m32;
  logic [3:0]  t32, ot32;

  pipelined_barrel_shifter #(.WIDTH(8), .TAG_W(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(ir8), .in_data(d8),
    .in_amt(a8), .in_mode(m8), .in_tag(t8), .out_valid(ov8), .out_ready(or8),
    .out_data(od8), .out_tag(ot8), .out_err(oe8)
  );

  pipelined_barrel_shifter #(.WIDTH(32), .TAG_W(4)) dut32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(ir32), .in_data(d32),
    .in_amt(a32), .in_mode(m32), .in_tag(t32), .out_valid(ov32), .out_ready(or32),
    .out_data(od32), .out_tag(ot32), .out_err(oe32)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: bit-by-bit placement straight from the operation definitions.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int a, input int m, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      case (m)
        0: if (i >= a) r[i] = d[i-a];
        1: if (i + a < w) r[i] = d[i+a];
        2: r[i] = (i + a < w) ? d[i+a] : d[w-1];
        3: r[i] = d[(i - a + w) % w];
        4: r[i] = d[(i + a) % w];
        default: r[i] = d[i];
      endcase
    end
    return r;
  endfunction

  typedef struct {
    logic [31:0] d;
    logic [3:0]  t;
    logic        e;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        e_pop;
  exp_t        e_push;
  int          cyc       = 0;
  bit          chk_lat   = 0;
  int          acc_cnt   = 0;
  int          res_cnt   = 0;
  int          first_out = -1;
  int          last_out  = -1;
  logic        hold_prev = 1'b0;
  logic [31:0] pd;
  logic [3:0]  pt;
  logic        pe;

  // Scoreboard for the 32-bit instance, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) chk("hold_stable", {ov32, od32, ot32, oe32}, {1'b1, pd, pt, pe});
      if (ov32 && or32) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_result: got data %0h tag %0h, expected none", od32, ot32);
        end else begin
          e_pop = q.pop_front();
          chk("res_data", od32, e_pop.d);
          chk("res_tag", ot32, e_pop.t);
          chk("res_err", oe32, e_pop.e);
          if (chk_lat) chk("res_latency", cyc - e_pop.cyc, SHW32);
          res_cnt++;
          if (first_out < 0) first_out = cyc;
          last_out = cyc;
        end
      end
      hold_prev = ov32 && !or32;
      pd = od32;
      pt = ot32;
      pe = oe32;
      if (v32 && ir32) begin
        e_push.d   = ref_shift(d32, int'(a32), int'(m32), 32);
        e_push.t   = t32;
        e_push.e   = (m32 > 3'd4);
        e_push.cyc = cyc;
        q.push_back(e_push);
        acc_cnt++;
      end
    end
  end

  task automatic drive32(input logic [31:0] d, input logic [4:0] a, input logic [2:0] m, input logic [3:0] t);
    v32 = 1'b1; d32 = d; a32 = a; m32 = m; t32 = t;
  endtask

  task automatic wait_drain(input string name, input int max);
    int n;
    n = 0;
    while (q.size() != 0 && n < max) begin
      step();
      n++;
    end
    chk(name, q.size(), 0);
  endtask

  typedef struct {
    logic [2:0] m;
    logic [7:0] d;
    logic [2:0] a;
    logic [3:0] t;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    v8 = 0; d8 = 0; a8 = 0; m8 = 0; t8 = 0; or8 = 1;
    v32 = 0; d32 = 0; a32 = 0; m32 = 0; t32 = 0; or32 = 1;

    tbl[0] = '{3'd0, 8'h96, 3'd3, 4'h1, 8'hB0};
    tbl[1] = '{3'd1, 8'h96, 3'd3, 4'h2, 8'h12};
    tbl[2] = '{3'd2, 8'h96, 3'd3, 4'h3, 8'hF2};
    tbl[3] = '{3'd3, 8'h96, 3'd3, 4'h4, 8'hB4};
    tbl[4] = '{3'd4, 8'h96, 3'd3, 4'h5, 8'hD2};
    tbl[5] = '{3'd0, 8'h96, 3'd0, 4'h6, 8'h96};
    tbl[6] = '{3'd1, 8'h96, 3'd0, 4'h7, 8'h96};
    tbl[7] = '{3'd2, 8'h96, 3'd0, 4'h8, 8'h96};
    tbl[8] = '{3'd3, 8'h96, 3'd0, 4'h9, 8'h96};
    tbl[9] = '{3'd4, 8'h96, 3'd0, 4'hA, 8'h96};

    repeat (2) step();
    chk("rst_out_valid32", ov32, 0);
    chk("rst_out_data32", od32, 0);
    chk("rst_out_tag32", ot32, 0);
    chk("rst_out_err32", oe32, 0);
    chk("rst_out_valid8", ov8, 0);
    rst = 1'b0;
    chk("post_rst_in_ready32", ir32, 1);
    chk("post_rst_in_ready8", ir8, 1);

    for (int i = 0; i < 10; i++) begin
      v8 = 1'b1; m8 = tbl[i].m; d8 = tbl[i].d; a8 = tbl[i].a; t8 = tbl[i].t;
      step();
      v8 = 1'b0;
      d8 = 8'($urandom); a8 = 3'($urandom); m8 = 3'($urandom); t8 = 4'($urandom);
      n = 0;
      while (!ov8 && n < 10) begin
        step();
        n++;
      end
      chk($sformatf("tbl%0d_latency", i), n, SHW8 - 1);
      chk($sformatf("tbl%0d_data", i), od8, tbl[i].exp);
      chk($sformatf("tbl%0d_tag", i), ot8, tbl[i].t);
      chk($sformatf("tbl%0d_err", i), oe8, 0);
      step();
      chk($sformatf("tbl%0d_drained", i), ov8, 0);
    end

    // Illegal mode followed by a legal op.
    chk_lat = 1;
    drive32(32'h12345678, 5'd7, 3'b110, 4'h5);
    step();
    drive32(32'h80000000, 5'd4, 3'b001, 4'h6);
    step();
    v32 = 1'b0;
    n = 0;
    while (!ov32 && n < 20) begin
      step();
      n++;
    end
    chk("ill_data", od32, 32'h12345678);
    chk("ill_err", oe32, 1);
    chk("ill_tag", ot32, 4'h5);
    step();
    chk("ill_next_valid", ov32, 1);
    chk("ill_next_data", od32, 32'h08000000);
    chk("ill_next_err", oe32, 0);
    wait_drain("ill_drain", 20);

    // Back-to-back random traffic.
    res_cnt = 0; first_out = -1; last_out = -1;
    for (int i = 0; i < 100; i++) begin
      drive32($urandom, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 4'($urandom));
      step();
    end
    v32 = 1'b0;
    wait_drain("rand_drain", 50);
    chk("rand_count", res_cnt, 100);
    chk("rand_throughput", last_out - first_out, 99);
    chk_lat = 0;

    // Output stall with input pressure.
    or32 = 1'b0; acc_cnt = 0; res_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      drive32($urandom, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 4)), 4'(i));
      step();
    end
    v32 = 1'b0;
    chk("bp_accepts", acc_cnt, SHW32);
    chk("bp_in_ready", ir32, 0);
    chk("bp_out_valid", ov32, 1);
    or32 = 1'b1;
    wait_drain("bp_drain", 20);
    step();
    chk("bp_results", res_cnt, SHW32);

    // Reset with operations in flight.
    or32 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive32($urandom, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 4)), 4'(i + 8));
      step();
    end
    v32 = 1'b0;
    n = 0;
    while (!ov32 && n < 20) begin
      step();
      n++;
    end
    chk("inflight_valid_before_rst", ov32, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", ov32, 0);
    chk("async_rst_data", od32, 0);
    chk("async_rst_tag", ot32, 0);
    step();
    rst = 1'b0;
    chk("rst_release_in_ready", ir32, 1);
    or32 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("no_stale_result", ov32, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, pipelined successor to the team's 8-bit combinational barrel shifter. Supports logical left/right, arithmetic right, rotate left/right on WIDTH-bit data. One registered stage per shift-amount bit, with a valid/ready handshake on both sides. Sits between the operand-fetch and writeback stages of the datapath; a sideband tag travels with each operation.

Parameters:
WIDTH, 32, data width; power of two, >= 2
TAG_W, 4, sideband tag width carried unchanged with each operation; >= 1
SHW, $clog2(WIDTH), shift-amount width and pipeline depth; derived, not overridden

Ports:
clk  in  1  clock, rising-edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  input operation valid
in_ready  out  1  shifter can accept input this cycle
in_data  in  WIDTH  operand
in_amt  in  SHW  shift amount, 0..WIDTH-1
in_mode  in  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; 101-111 illegal
in_tag  in  TAG_W  sideband tag
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  WIDTH  shifted result
out_tag  out  TAG_W  tag of this result
out_err  out  1  1 = operation had an illegal mode

Behaviour:
- Reset: clk single clock; rst asynchronous, active-high. All stage valids, out_valid, out_data, out_tag and out_err clear to 0 immediately on rst assertion. in_ready = 1 in the first cycle after rst deasserts.
- Pipeline: SHW register stages. Stage k (k = 0..SHW-1) applies a shift of 2^k when in_amt bit k is set. Stage k also carries the remaining amount bits, mode, tag and err. The last stage drives out_*.
- Latency: exactly SHW cycles from accept (in_valid & in_ready) to out_valid when out_ready is held 1. Throughput is 1 operation per cycle.
- Handshake: stage k loads when it is empty or stage k+1 loads (or, for the last stage, out_ready = 1). in_ready = stage-0 load condition. Bubbles collapse, so a stalled output fills the pipe.
- Transfer occurs only on valid & ready. out_data, out_tag and out_err stay stable while out_valid = 1 and out_ready = 0.
- A change on in_* while in_valid = 0 has no effect.
- Arithmetic: SLL and SRL zero-fill. SRA fills with in_data[WIDTH-1]. ROL and ROR rotate modulo WIDTH.
- Implementation: left operations may be done by bit-reversing around a right shifter.
- in_amt = 0 gives out_data = in_data for every legal mode.
- Illegal mode (101-111): out_data = in_data unshifted, out_err = 1, tag preserved. The pipeline is not stalled.
- Order is strictly preserved; there is no reordering and no drop.
- If rst is asserted mid-operation, in-flight operations are discarded. There is no partial output.

Decomposition:
- Shared package shifter_pkg holds the mode encoding constants (MODE_SLL, MODE_SRL, MODE_SRA, MODE_ROL, MODE_ROR) and a packed stage-payload typedef parametrised by WIDTH/TAG_W (data, remaining amount, mode, tag, err). Parametrised payloads may be done as a macro or per-instance struct.
- One sub-module, shift_stage. It has parameters WIDTH, TAG_W and STEP (= 2^k), and contains one register stage plus its valid/ready logic. It is instantiated SHW times in a generate loop. The top level does input mode decode/reversal and output reversal.

Test Plan:
- WIDTH=8: SLL, data 0x96, amt 3 -> 0xB0 after 3 cycles, tag echoed. SRL, data 0x96, amt 3 -> 0x12.
- WIDTH=8: SRA, data 0x96, amt 3 -> 0xF2. ROL, data 0x96, amt 3 -> 0xB4. ROR, data 0x96, amt 3 -> 0xD2. Each with amt 0 -> 0x96.
- WIDTH=32: back-to-back 100 random ops with out_ready = 1 -> 1 result/cycle, first result at cycle 5, results match a reference model in order, tags match.
- Backpressure: out_ready = 0 for 10 cycles while in_valid = 1. in_ready drops after 5 accepts, out_* held stable. Release out_ready -> all 5 results drain in order with none lost or duplicated.
- Illegal mode 110, data 0x12345678, amt 7 -> out_data 0x12345678, out_err = 1. The following legal op has out_err = 0.
- Assert rst with 3 ops in flight -> out_valid = 0 immediately and no stale results after release. in_ready = 1 the next cycle.
